// File: rtl/matvec_pkg.sv
// Shared widths, saturation limits and the output entry layout for the matvec post-processing stage.
package matvec_pkg;

   localparam int unsigned DATA_IN_W  = 14;
   localparam int unsigned RESULT_W   = 28;
   localparam int unsigned OUT_W      = 16;
   localparam int          SAT_MAX    = 32767;
   localparam int          SAT_MIN    = -32768;
   localparam int unsigned GROUP_SIZE = 3;

   // One buffered output: saturated result plus its end-of-group flag.
   typedef struct packed {
      logic             last;
      logic [OUT_W-1:0] data;
   } pp_entry_t;

endpackage

// File: rtl/postproc_fifo.sv
// Valid/ready FIFO with an internal occupancy count and registered head/ready/valid outputs.
// Ports: clk, reset (async, active-low), i_push/i_wdata (write side, gated by o_ready),
//        i_pop (read side, gated by o_valid), o_ready, o_valid, o_rdata (head entry).
module postproc_fifo #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_rdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_ready;
   logic             r_valid;
   logic [WIDTH-1:0] r_rdata;

   logic             w_push;
   logic             w_pop;
   logic [AW-1:0]    w_wr_ptr_n;
   logic [AW-1:0]    w_rd_ptr_n;
   logic [CW-1:0]    w_count_n;
   logic [WIDTH-1:0] w_head_n;

   // Next pointers/count; the head bypasses the array when a push lands in the slot being exposed.
   always_comb begin
      w_push     = i_push && r_ready;
      w_pop      = i_pop && r_valid;
      w_wr_ptr_n = w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      w_rd_ptr_n = w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
      w_count_n  = r_count + CW'(w_push) - CW'(w_pop);
      w_head_n   = (w_push && (r_wr_ptr == w_rd_ptr_n)) ? i_wdata : r_mem[w_rd_ptr_n];
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
         r_valid  <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_n;
         r_rd_ptr <= w_rd_ptr_n;
         r_count  <= w_count_n;
         r_ready  <= (w_count_n < CW'(DEPTH));
         r_valid  <= (w_count_n != '0);
         r_rdata  <= w_head_n;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_rdata = r_rdata;

endmodule

// File: rtl/matvec_postproc.sv
// Post-processing of matvec results: arithmetic shift, optional ReLU, 16-bit saturation,
// group-end tagging, then buffering in a FIFO toward the downstream consumer.
// Ports: clk, reset (async, active-low), input_valid/input_ready/input_data (28-bit signed in),
//        output_valid/output_ready/output_data (16-bit signed out), output_last (end of group).
module matvec_postproc
   import matvec_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned SHIFT = 0,
   parameter int unsigned RELU  = 1,
   parameter int unsigned GROUP = GROUP_SIZE
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       input_valid,
   output logic                       input_ready,
   input  logic signed [RESULT_W-1:0] input_data,
   output logic                       output_valid,
   input  logic                       output_ready,
   output logic signed [OUT_W-1:0]    output_data,
   output logic                       output_last
);

   localparam int unsigned GW = (GROUP > 1) ? $clog2(GROUP) : 1;
   localparam logic signed [RESULT_W-1:0] L_MAX = RESULT_W'(SAT_MAX);
   localparam logic signed [RESULT_W-1:0] L_MIN = RESULT_W'(SAT_MIN);

   logic [GW-1:0]              r_grp;
   logic signed [RESULT_W-1:0] w_shift;
   logic signed [RESULT_W-1:0] w_clip;
   logic [OUT_W-1:0]           w_sat;
   logic                       w_grp_end;
   logic                       w_in_xfer;
   pp_entry_t                  w_entry;
   pp_entry_t                  w_head;

   // Shift (floor), ReLU clamp, then saturate into the output range.
   always_comb begin
      w_shift = input_data >>> SHIFT;
      w_clip  = w_shift;
      if ((RELU != 0) && w_shift[RESULT_W-1]) w_clip = '0;
      if (w_clip > L_MAX)      w_sat = OUT_W'(SAT_MAX);
      else if (w_clip < L_MIN) w_sat = OUT_W'(SAT_MIN);
      else                     w_sat = w_clip[OUT_W-1:0];
      w_grp_end     = (r_grp == GW'(GROUP - 1));
      w_in_xfer     = input_valid && input_ready;
      w_entry.last  = w_grp_end;
      w_entry.data  = w_sat;
   end

   // Position of the next accepted result within its group.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         r_grp <= '0;
      else if (w_in_xfer) r_grp <= w_grp_end ? '0 : r_grp + GW'(1);
   end

   postproc_fifo #(
      .WIDTH ($bits(pp_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (input_valid),
      .i_wdata (w_entry),
      .i_pop   (output_ready),
      .o_ready (input_ready),
      .o_valid (output_valid),
      .o_rdata (w_head)
   );

   assign output_data = w_head.data;
   assign output_last = w_head.last;

endmodule

// File: tb/tb_matvec_postproc.sv
// Three post-processors with different SHIFT/RELU settings share one handshake stream and are
// each compared against a queue-based reference of the expected output sequence.
module tb_matvec_postproc;

   localparam int DEPTH = 4;
   localparam int GROUP = 3;

   typedef struct { int d; bit l; } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        input_valid;
   logic        output_ready;
   logic [27:0] input_data;
   logic        ir [3];
   logic        ov [3];
   logic        ol [3];
   logic [15:0] od [3];

   int   sh [3] = '{0, 8, 0};
   bit   rl [3] = '{1'b1, 1'b0, 1'b0};
   exp_t q  [3][$];
   int   m_grp = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_acc = 0;

   always #5 clk = ~clk;

   matvec_postproc #(.DEPTH(DEPTH), .SHIFT(0), .RELU(1), .GROUP(GROUP)) u_a (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir[0]),
      .input_data(input_data), .output_valid(ov[0]), .output_ready(output_ready),
      .output_data(od[0]), .output_last(ol[0]));
   matvec_postproc #(.DEPTH(DEPTH), .SHIFT(8), .RELU(0), .GROUP(GROUP)) u_b (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir[1]),
      .input_data(input_data), .output_valid(ov[1]), .output_ready(output_ready),
      .output_data(od[1]), .output_last(ol[1]));
   matvec_postproc #(.DEPTH(DEPTH), .SHIFT(0), .RELU(0), .GROUP(GROUP)) u_c (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir[2]),
      .input_data(input_data), .output_valid(ov[2]), .output_ready(output_ready),
      .output_data(od[2]), .output_last(ol[2]));

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference post-processing straight from the arithmetic rules.
   function automatic int pp(input logic [27:0] raw, input int shift, input bit relu);
      int v;
      v = int'($signed(raw)) >>> shift;
      if (relu && v < 0) v = 0;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      return v;
   endfunction

   // Check outputs against the model, advance one clock, then apply the transfers that happened.
   task automatic step(output bit acc);
      bit in_x, out_x;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ready%0d", i), int'(ir[i]), int'(q[i].size() < DEPTH));
         chk($sformatf("valid%0d", i), int'(ov[i]), int'(q[i].size() > 0));
         if (q[i].size() > 0) begin
            chk($sformatf("data%0d", i), int'($signed(od[i])), q[i][0].d);
            chk($sformatf("last%0d", i), int'(ol[i]), int'(q[i][0].l));
         end
      end
      in_x  = input_valid && (q[0].size() < DEPTH);
      out_x = output_ready && (q[0].size() > 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (out_x) void'(q[i].pop_front());
         if (in_x)  q[i].push_back('{d: pp(input_data, sh[i], rl[i]), l: (m_grp == GROUP - 1)});
      end
      if (in_x) begin
         m_grp = (m_grp == GROUP - 1) ? 0 : m_grp + 1;
         n_acc++;
      end
      acc = in_x;
   endtask

   task automatic send(input int v);
      bit acc;
      input_valid = 1'b1;
      input_data  = 28'(v);
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) step(acc);
      if (!acc) chk("send_timeout", 0, 1);
      input_valid = 1'b0;
      input_data  = 'x;
   endtask

   task automatic drain();
      bit acc;
      output_ready = 1'b1;
      for (int k = 0; k < 3 * DEPTH; k++) step(acc);
   endtask

   task automatic check_in_reset();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_valid%0d", i), int'(ov[i]), 0);
         chk($sformatf("rst_last%0d", i),  int'(ol[i]), 0);
         chk($sformatf("rst_data%0d", i),  int'(od[i]), 0);
         chk($sformatf("rst_ready%0d", i), int'(ir[i]), 0);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #1;
      check_in_reset();
      for (int i = 0; i < 3; i++) q[i].delete();
      m_grp = 0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  dir [9] = '{-800, -1200, 8400, -800, 8400, 255, 40000, -40000, 7};
      int  v5  [5];
      int  idx;
      int  cyc;
      bit  acc;
      reset        = 1'b0;
      input_valid  = 1'b0;
      output_ready = 1'b0;
      input_data   = '0;
      #2;
      apply_reset();

      // Directed arithmetic cases: negative, ReLU, shift floor, saturation, group tagging.
      output_ready = 1'b1;
      foreach (dir[k]) send(dir[k]);
      drain();

      // Back-pressure: fill the FIFO, hold input_valid, release exactly one pop.
      for (int k = 0; k < 5; k++) v5[k] = int'($urandom_range(0, 60000)) - 30000;
      output_ready = 1'b0;
      input_valid  = 1'b1;
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         input_data = 28'(v5[idx]);
         step(acc);
         if (acc) idx++;
      end
      chk("accepted_while_stalled", idx, DEPTH);
      output_ready = 1'b1;
      step(acc);
      chk("no_pass_through_when_full", int'(acc), 0);
      output_ready = 1'b0;
      step(acc);
      chk("fifth_after_pop", int'(acc), 1);
      input_valid = 1'b0;
      input_data  = 'x;
      drain();

      // Random handshakes over 30 results.
      apply_reset();
      n_acc = 0;
      cyc   = 0;
      while ((n_acc < 30 || q[0].size() > 0) && cyc < 2000) begin
         input_valid  = (n_acc < 30) && ($urandom_range(0, 2) != 0);
         output_ready = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 2))
            0:       input_data = 28'($urandom);
            1:       input_data = 28'(int'($urandom_range(0, 4000)) - 2000);
            default: input_data = 28'(int'($urandom_range(0, 200000)) - 100000);
         endcase
         if (!input_valid) input_data = 'x;
         step(acc);
         cyc++;
      end
      if (cyc >= 2000) chk("random_timeout", 0, 1);
      chk("random_results_accepted", n_acc, 30);
      input_valid = 1'b0;
      drain();

      // Reset in the middle of a group with two results buffered.
      apply_reset();
      output_ready = 1'b0;
      send(1000);
      send(-2000);
      #2;
      reset = 1'b0;
      #1;
      check_in_reset();
      for (int i = 0; i < 3; i++) q[i].delete();
      m_grp = 0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      output_ready = 1'b1;
      send(5000);
      send(-6000);
      send(70000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
